// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single mmu memory port between the instruction-fetch requester and the
//   load/store requester. One requester is granted at a time. Each transaction runs
//   IDLE -> ISSUE -> WAIT -> DONE -> IDLE, where WAIT lasts READ_LATENCY-1 cycles and is
//   skipped when READ_LATENCY is 1. Data is returned with a one-cycle valid pulse. The
//   UART window (0x200-0x202) is treated exactly like RAM; the mmu does the decoding.
//
// Ports
//   clock, RST                   clock (posedge) and asynchronous active-high reset
//   ifReq, ifAddr                fetch request and address
//   ifGnt, ifValid, ifData       fetch accept pulse, data-valid pulse, fetched word
//   dReq, dAddr, dWData,         data request, address, store data,
//   dByteEna, dWE                store byte enables, 1 = store / 0 = load
//   dGnt, dValid, dRData         data accept pulse, done pulse, load data
//   memVaddr, memData,           mmu address, write data,
//   memByteena, memWE            byte enables, write enable
//   memQ                         mmu read data
//   busy                         high whenever a transaction is in flight
module mem_port_arbiter #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        RST,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic        ifGnt,
    output logic        ifValid,
    output logic [31:0] ifData,
    input  logic        dReq,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    input  logic [3:0]  dByteEna,
    input  logic        dWE,
    output logic        dGnt,
    output logic        dValid,
    output logic [31:0] dRData,
    output logic [31:0] memVaddr,
    output logic [31:0] memData,
    output logic [3:0]  memByteena,
    output logic        memWE,
    input  logic [31:0] memQ,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int unsigned WaitW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]         state;
    logic [31:0]        capAddr;
    logic [31:0]        capData;
    logic [3:0]         capBe;
    logic               capWe;
    logic               capFetch;
    logic [WaitW-1:0]   waitCnt;
    logic [StarveW-1:0] starveCnt;

    logic idle;
    logic starved;
    logic fetchWins;

    assign idle      = (state == IDLE);
    assign starved   = (starveCnt == StarveW'(STARVE_LIMIT));
    // Data has priority unless fetch has been passed over STARVE_LIMIT times in a row.
    assign fetchWins = ifReq && (!dReq || starved);
    assign ifGnt     = idle && fetchWins;
    assign dGnt      = idle && dReq && !fetchWins;

    // Address/data stay on the port from ISSUE until the next grant recaptures them;
    // strobes are only live during ISSUE.
    assign memVaddr   = capAddr;
    assign memData    = capData;
    assign memWE      = (state == ISSUE) && capWe;
    assign memByteena = (state == ISSUE) ? capBe : 4'h0;
    assign busy       = !idle;

    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            capAddr   <= 32'h0;
            capData   <= 32'h0;
            capBe     <= 4'h0;
            capWe     <= 1'b0;
            capFetch  <= 1'b0;
            waitCnt   <= '0;
            starveCnt <= '0;
            ifValid   <= 1'b0;
            dValid    <= 1'b0;
            ifData    <= 32'h0;
            dRData    <= 32'h0;
        end else begin
            ifValid <= 1'b0;
            dValid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ifGnt) begin
                        capAddr   <= ifAddr;
                        capData   <= 32'h0;
                        capBe     <= 4'hF;
                        capWe     <= 1'b0;
                        capFetch  <= 1'b1;
                        starveCnt <= '0;
                        state     <= ISSUE;
                    end else if (dGnt) begin
                        capAddr  <= dAddr;
                        capData  <= dWData;
                        capBe    <= dByteEna;
                        capWe    <= dWE;
                        capFetch <= 1'b0;
                        state    <= ISSUE;
                        if (!ifReq) begin
                            starveCnt <= '0;
                        end else if (!starved) begin
                            starveCnt <= starveCnt + 1'b1;
                        end
                    end else if (!ifReq) begin
                        starveCnt <= '0;
                    end
                end
                ISSUE: begin
                    if (READ_LATENCY == 1) begin
                        state <= DONE;
                    end else begin
                        // Counts the remaining WAIT cycles after this one.
                        waitCnt <= WaitW'(READ_LATENCY - 2);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt == '0) begin
                        state <= DONE;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                DONE: begin
                    if (capFetch) begin
                        ifData  <= memQ;
                        ifValid <= 1'b1;
                    end else begin
                        // Stores only acknowledge; dRData keeps the last load result.
                        if (!capWe) begin
                            dRData <= memQ;
                        end
                        dValid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Main instance uses READ_LATENCY=2, STARVE_LIMIT=4;
// a second instance with READ_LATENCY=1 shares the inputs and is checked only in the
// latency-1 step. Read data from the main instance is compared through a scoreboard.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        RST;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dReq;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic [3:0]  dByteEna;
    logic        dWE;

    logic        ifGnt, ifValid, dGnt, dValid, memWE, busy;
    logic [31:0] ifData, dRData, memVaddr, memData, memQ;
    logic [3:0]  memByteena;

    logic        ifGnt1, ifValid1, dGnt1, dValid1, memWE1, busy1;
    logic [31:0] ifData1, dRData1, memVaddr1, memData1, memQ1;
    logic [3:0]  memByteena1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int g;

    logic [31:0] fq[$];
    logic [31:0] dq[$];
    logic [31:0] lastLoad = 32'h0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    // Main instance sees a fixed function of its address; the latency-1 instance sees a
    // cycle stamp so the sampling cycle is visible in the returned word.
    assign memQ  = memf(memVaddr);
    assign memQ1 = {16'hC0DE, cyc[15:0]};

    mem_port_arbiter #(.READ_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clock(clock), .RST(RST),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifValid(ifValid), .ifData(ifData),
        .dReq(dReq), .dAddr(dAddr), .dWData(dWData), .dByteEna(dByteEna), .dWE(dWE),
        .dGnt(dGnt), .dValid(dValid), .dRData(dRData),
        .memVaddr(memVaddr), .memData(memData), .memByteena(memByteena), .memWE(memWE),
        .memQ(memQ), .busy(busy)
    );

    mem_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clock(clock), .RST(RST),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt1), .ifValid(ifValid1), .ifData(ifData1),
        .dReq(dReq), .dAddr(dAddr), .dWData(dWData), .dByteEna(dByteEna), .dWE(dWE),
        .dGnt(dGnt1), .dValid(dValid1), .dRData(dRData1),
        .memVaddr(memVaddr1), .memData(memData1), .memByteena(memByteena1), .memWE(memWE1),
        .memQ(memQ1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!RST) begin
            if (ifValid) begin
                if (fq.size() == 0) check("ifValid_unexpected", {31'h0, ifValid}, 32'h0);
                else check("sb_ifData", ifData, fq.pop_front());
            end
            if (dValid) begin
                if (dq.size() == 0) check("dValid_unexpected", {31'h0, dValid}, 32'h0);
                else check("sb_dRData", dRData, dq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; ifReq = 1'b0; ifAddr = 32'h0; dReq = 1'b0; dAddr = 32'h0;
        dWData = 32'h0; dByteEna = 4'h0; dWE = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_gnt", {30'h0, ifGnt, dGnt}, 32'h0);
        check("rst_valid", {30'h0, ifValid, dValid}, 32'h0);
        check("rst_memWE", {31'h0, memWE}, 32'h0);
        check("rst_memByteena", {28'h0, memByteena}, 32'h0);
        check("rst_memVaddr", memVaddr, 32'h0);
        check("rst_memData", memData, 32'h0);
        check("rst_ifData", ifData, 32'h0);
        check("rst_dRData", dRData, 32'h0);
        @(negedge clock);
        RST = 1'b0;

        // 1: lone fetch
        @(negedge clock);
        ifReq = 1'b1; ifAddr = 32'h10;
        #1;
        check("t1_ifGnt", {31'h0, ifGnt}, 32'h1);
        check("t1_dGnt", {31'h0, dGnt}, 32'h0);
        fq.push_back(memf(32'h10));
        @(negedge clock);
        ifReq = 1'b0;
        check("t1_issue_memWE", {31'h0, memWE}, 32'h0);
        check("t1_issue_be", {28'h0, memByteena}, 32'hF);
        check("t1_issue_addr", memVaddr, 32'h10);
        check("t1_issue_busy", {31'h0, busy}, 32'h1);
        @(negedge clock);
        check("t1_wait_be", {28'h0, memByteena}, 32'h0);
        check("t1_wait_valid", {31'h0, ifValid}, 32'h0);
        @(negedge clock);
        check("t1_done_valid", {31'h0, ifValid}, 32'h0);
        check("t1_done_busy", {31'h0, busy}, 32'h1);
        @(negedge clock);
        check("t1_valid", {31'h0, ifValid}, 32'h1);
        check("t1_ifData", ifData, 32'hDEADBEFF);
        check("t1_idle", {31'h0, busy}, 32'h0);
        @(negedge clock);
        check("t1_valid_pulse", {31'h0, ifValid}, 32'h0);

        // 2: simultaneous requests, data first, fetch granted on the dValid cycle
        @(negedge clock);
        ifReq = 1'b1; ifAddr = 32'h100; dReq = 1'b1; dWE = 1'b0; dAddr = 32'h20;
        #1;
        check("t2_dGnt", {31'h0, dGnt}, 32'h1);
        check("t2_ifGnt_blocked", {31'h0, ifGnt}, 32'h0);
        dq.push_back(memf(32'h20));
        lastLoad = memf(32'h20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            dReq = 1'b0;
            check("t2_no_gnt_busy", {31'h0, ifGnt}, 32'h0);
        end
        @(negedge clock);
        check("t2_dValid", {31'h0, dValid}, 32'h1);
        check("t2_ifGnt_b2b", {31'h0, ifGnt}, 32'h1);
        fq.push_back(memf(32'h100));
        @(negedge clock);
        ifReq = 1'b0;
        repeat (3) @(negedge clock);
        check("t2_ifValid", {31'h0, ifValid}, 32'h1);

        // 3: both held; fetch forced after four data grants
        @(negedge clock);
        ifReq = 1'b1; ifAddr = 32'h34; dReq = 1'b1; dWE = 1'b0; dAddr = 32'h30;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) repeat (4) @(negedge clock);
            #1;
            if (k == 4) begin
                check("t3_ifGnt", {30'h0, ifGnt, dGnt}, 32'h2);
                fq.push_back(memf(32'h34));
            end else begin
                check("t3_dGnt", {30'h0, ifGnt, dGnt}, 32'h1);
                dq.push_back(memf(32'h30));
                lastLoad = memf(32'h30);
            end
        end
        @(negedge clock);
        ifReq = 1'b0; dReq = 1'b0;
        repeat (4) @(negedge clock);

        // 4: store leaves dRData alone and strobes for exactly one cycle
        @(negedge clock);
        dReq = 1'b1; dWE = 1'b1; dAddr = 32'h40; dWData = 32'h12345678; dByteEna = 4'b0011;
        #1;
        check("t4_dGnt", {31'h0, dGnt}, 32'h1);
        dq.push_back(lastLoad);
        @(negedge clock);
        dReq = 1'b0; dWE = 1'b0;
        check("t4_memWE", {31'h0, memWE}, 32'h1);
        check("t4_be", {28'h0, memByteena}, 32'h3);
        check("t4_addr", memVaddr, 32'h40);
        check("t4_data", memData, 32'h12345678);
        @(negedge clock);
        check("t4_memWE_fall", {31'h0, memWE}, 32'h0);
        check("t4_be_fall", {28'h0, memByteena}, 32'h0);
        repeat (2) @(negedge clock);
        check("t4_dValid", {31'h0, dValid}, 32'h1);
        check("t4_dRData_kept", dRData, lastLoad);

        // 5: reset during WAIT aborts with no valid; then reset during a store's ISSUE
        @(negedge clock);
        ifReq = 1'b1; ifAddr = 32'h50;
        #1;
        check("t5_ifGnt", {31'h0, ifGnt}, 32'h1);
        @(negedge clock);
        ifReq = 1'b0;
        @(negedge clock);
        RST = 1'b1; lastLoad = 32'h0;
        #1;
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_memWE", {31'h0, memWE}, 32'h0);
        check("t5_memVaddr", memVaddr, 32'h0);
        @(negedge clock);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t5_no_valid", {31'h0, ifValid}, 32'h0);
        end
        @(negedge clock);
        dReq = 1'b1; dWE = 1'b1; dAddr = 32'h44; dWData = 32'hAAAA5555; dByteEna = 4'hF;
        #1;
        check("t5_store_dGnt", {31'h0, dGnt}, 32'h1);
        @(negedge clock);
        dReq = 1'b0; dWE = 1'b0;
        check("t5_store_memWE", {31'h0, memWE}, 32'h1);
        RST = 1'b1;
        #1;
        check("t5_memWE_async", {31'h0, memWE}, 32'h0);
        check("t5_be_async", {28'h0, memByteena}, 32'h0);
        @(negedge clock);
        RST = 1'b0;
        @(negedge clock);
        ifReq = 1'b1; ifAddr = 32'h0;
        #1;
        check("t5_fetch_gnt", {31'h0, ifGnt}, 32'h1);
        fq.push_back(memf(32'h0));
        @(negedge clock);
        ifReq = 1'b0;
        repeat (3) @(negedge clock);
        check("t5_fetch_valid", {31'h0, ifValid}, 32'h1);
        check("t5_fetch_data", ifData, 32'hDEADBEEF);

        // 6: latency-1 instance skips WAIT and samples memQ in the DONE cycle
        @(negedge clock);
        ifReq = 1'b1; ifAddr = 32'h4;
        #1;
        check("t6_ifGnt", {31'h0, ifGnt1}, 32'h1);
        g = cyc;
        fq.push_back(memf(32'h4));
        @(negedge clock);
        ifReq = 1'b0;
        check("t6_issue_busy", {31'h0, busy1}, 32'h1);
        check("t6_issue_addr", memVaddr1, 32'h4);
        @(negedge clock);
        check("t6_done_valid", {31'h0, ifValid1}, 32'h0);
        check("t6_done_busy", {31'h0, busy1}, 32'h1);
        @(negedge clock);
        check("t6_valid", {31'h0, ifValid1}, 32'h1);
        check("t6_ifData", ifData1, {16'hC0DE, 16'(g + 2)});
        check("t6_idle", {31'h0, busy1}, 32'h0);
        @(negedge clock);
        check("t6_valid_pulse", {31'h0, ifValid1}, 32'h0);
        repeat (4) @(negedge clock);

        check("sb_fetch_drained", fq.size(), 32'h0);
        check("sb_data_drained", dq.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
